// File: rtl/ahb_lite_pkg.sv
// Shared AHB-Lite encodings, copy-master and port state types, and an address helper.
package ahb_lite_pkg;

  localparam logic [1:0]  HTRANS_IDLE     = 2'b00;
  localparam logic [1:0]  HTRANS_NONSEQ   = 2'b10;
  localparam logic [2:0]  HSIZE_WORD      = 3'b010;
  localparam logic [2:0]  HBURST_SINGLE   = 3'b000;
  localparam logic [3:0]  HPROT_DATA_PRIV = 4'b0011;
  localparam logic        HRESP_OKAY      = 1'b0;
  localparam logic        HRESP_ERROR     = 1'b1;
  localparam logic [31:0] WORD_BYTES      = 32'd4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_ADDR,
    ST_RD_DATA,
    ST_WR_ADDR,
    ST_WR_DATA,
    ST_FINISH
  } copy_state_t;

  typedef enum logic [1:0] {
    PH_IDLE,
    PH_ADDR,
    PH_DATA
  } port_phase_t;

  function automatic logic [31:0] word_align(input logic [31:0] a);
    return a & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/ahb_lite_master_port.sv
// Single-transfer AHB-Lite master port: one NONSEQ address phase, then one data phase.
// Address/control are registered and held through HREADY=0; ack pulses on the data-phase completion cycle.
module ahb_lite_master_port
  import ahb_lite_pkg::*;
(
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        addr_done,
  output logic        ack,
  output logic        err,
  output logic        resp_err,
  output logic [31:0] rdata,
  output logic [31:0] HADDR,
  output logic [1:0]  HTRANS,
  output logic [2:0]  HSIZE,
  output logic [2:0]  HBURST,
  output logic [3:0]  HPROT,
  output logic        HMASTLOCK,
  output logic        HWRITE,
  output logic [31:0] HWDATA,
  input  logic        HREADY,
  input  logic [31:0] HRDATA,
  input  logic        HRESP
);

  port_phase_t phase, phase_nxt;
  logic        launch;

  assign HSIZE     = HSIZE_WORD;
  assign HBURST    = HBURST_SINGLE;
  assign HPROT     = HPROT_DATA_PRIV;
  assign HMASTLOCK = 1'b0;

  assign addr_done = (phase == PH_ADDR) && HREADY;
  assign ack       = (phase == PH_DATA) && HREADY;
  assign err       = (HRESP == HRESP_ERROR);
  assign resp_err  = (phase == PH_DATA) && (HRESP == HRESP_ERROR);
  assign rdata     = HRDATA;
  // A new request is taken when idle or back-to-back with the completing data phase.
  assign launch    = req && ((phase == PH_IDLE) || ack);

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) phase <= PH_IDLE;
    else          phase <= phase_nxt;
  end

  always_comb begin
    phase_nxt = phase;
    case (phase)
      PH_IDLE: if (req) phase_nxt = PH_ADDR;
      PH_ADDR: if (HREADY) phase_nxt = PH_DATA;
      PH_DATA: if (HREADY) phase_nxt = req ? PH_ADDR : PH_IDLE;
      default: phase_nxt = PH_IDLE;
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      HADDR  <= '0;
      HTRANS <= HTRANS_IDLE;
      HWRITE <= 1'b0;
      HWDATA <= '0;
    end else if (launch) begin
      HADDR  <= addr;
      HTRANS <= HTRANS_NONSEQ;
      HWRITE <= we;
    end else if (addr_done) begin
      HTRANS <= HTRANS_IDLE;
      HWRITE <= 1'b0;
      if (HWRITE) HWDATA <= wdata;
    end
  end

endmodule

// File: rtl/ahb_lite_copy_master.sv
// Block-copy AHB-Lite initiator: read word, write word, repeat; 4 cycles/word with zero waits.
// Stalls on HREADY=0 and aborts the copy on an ERROR response.
module ahb_lite_copy_master
  import ahb_lite_pkg::*;
#(
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   HCLK,
  input  logic                   HRESETn,
  input  logic                   start,
  input  logic [31:0]            srcAddr,
  input  logic [31:0]            dstAddr,
  input  logic [COUNT_WIDTH-1:0] wordCount,
  output logic                   busy,
  output logic                   done,
  output logic                   error,
  output logic [31:0]            errAddr,
  output logic [31:0]            HADDR,
  output logic [1:0]             HTRANS,
  output logic [2:0]             HSIZE,
  output logic [2:0]             HBURST,
  output logic [3:0]             HPROT,
  output logic                   HMASTLOCK,
  output logic                   HWRITE,
  output logic [31:0]            HWDATA,
  input  logic                   HREADY,
  input  logic [31:0]            HRDATA,
  input  logic                   HRESP
);

  copy_state_t            state, state_nxt;
  logic [31:0]            src, dst, buffer;
  logic [COUNT_WIDTH-1:0] remaining;
  logic                   req, we;
  logic [31:0]            req_addr;
  logic                   addr_done, ack, port_err, resp_err;
  logic [31:0]            rdata;
  logic                   accept_start, abort, in_data;

  assign accept_start = (state == ST_IDLE) && start;
  assign in_data      = (state == ST_RD_DATA) || (state == ST_WR_DATA);
  assign abort        = in_data && ack && port_err;

  ahb_lite_master_port u_port (
    .HCLK      (HCLK),
    .HRESETn   (HRESETn),
    .req       (req),
    .we        (we),
    .addr      (req_addr),
    .wdata     (buffer),
    .addr_done (addr_done),
    .ack       (ack),
    .err       (port_err),
    .resp_err  (resp_err),
    .rdata     (rdata),
    .HADDR     (HADDR),
    .HTRANS    (HTRANS),
    .HSIZE     (HSIZE),
    .HBURST    (HBURST),
    .HPROT     (HPROT),
    .HMASTLOCK (HMASTLOCK),
    .HWRITE    (HWRITE),
    .HWDATA    (HWDATA),
    .HREADY    (HREADY),
    .HRDATA    (HRDATA),
    .HRESP     (HRESP)
  );

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  // Requests are issued in the cycle the previous phase completes so the port registers them without a bubble.
  always_comb begin
    state_nxt = state;
    req       = 1'b0;
    we        = 1'b0;
    req_addr  = src;
    case (state)
      ST_IDLE: if (start) begin
        if (wordCount == '0) begin
          state_nxt = ST_FINISH;
        end else begin
          state_nxt = ST_RD_ADDR;
          req       = 1'b1;
          req_addr  = word_align(srcAddr);
        end
      end
      ST_RD_ADDR: if (addr_done) state_nxt = ST_RD_DATA;
      ST_RD_DATA: if (ack) begin
        if (port_err) begin
          state_nxt = ST_FINISH;
        end else begin
          state_nxt = ST_WR_ADDR;
          req       = 1'b1;
          we        = 1'b1;
          req_addr  = dst;
        end
      end
      ST_WR_ADDR: if (addr_done) state_nxt = ST_WR_DATA;
      ST_WR_DATA: if (ack) begin
        if (port_err || remaining == COUNT_WIDTH'(1)) begin
          state_nxt = ST_FINISH;
        end else begin
          state_nxt = ST_RD_ADDR;
          req       = 1'b1;
          req_addr  = src + WORD_BYTES;
        end
      end
      ST_FINISH: state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      src       <= '0;
      dst       <= '0;
      remaining <= '0;
      buffer    <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
      errAddr   <= '0;
    end else begin
      busy  <= (state_nxt != ST_IDLE);
      done  <= (state_nxt == ST_FINISH);
      error <= abort;
      if (accept_start) begin
        src       <= word_align(srcAddr);
        dst       <= word_align(dstAddr);
        remaining <= wordCount;
        errAddr   <= '0;
      end
      if (resp_err && state == ST_RD_DATA) errAddr <= src;
      if (resp_err && state == ST_WR_DATA) errAddr <= dst;
      if (state == ST_RD_DATA && ack && !port_err) buffer <= rdata;
      if (state == ST_WR_DATA && ack && !port_err) begin
        src       <= src + WORD_BYTES;
        dst       <= dst + WORD_BYTES;
        remaining <= remaining - COUNT_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_ahb_lite_copy_master.sv
// Directed bench for ahb_lite_copy_master: behavioural AHB-Lite slave with wait/error injection
// and a scoreboard of expected transfers popped as each address phase is accepted.
`timescale 1ns/1ps
module tb_ahb_lite_copy_master;
  import ahb_lite_pkg::*;

  logic        HCLK = 1'b0;
  logic        HRESETn = 1'b0;
  logic        start = 1'b0;
  logic [31:0] srcAddr = '0, dstAddr = '0;
  logic [15:0] wordCount = '0;
  logic        busy, done, error;
  logic [31:0] errAddr, HADDR, HWDATA;
  logic [1:0]  HTRANS;
  logic [2:0]  HSIZE, HBURST;
  logic [3:0]  HPROT;
  logic        HMASTLOCK, HWRITE;
  logic        HREADY = 1'b1;
  logic [31:0] HRDATA = '0;
  logic        HRESP = 1'b0;

  always #5 HCLK = ~HCLK;

  ahb_lite_copy_master #(.COUNT_WIDTH(16)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .start(start), .srcAddr(srcAddr), .dstAddr(dstAddr),
    .wordCount(wordCount), .busy(busy), .done(done), .error(error), .errAddr(errAddr),
    .HADDR(HADDR), .HTRANS(HTRANS), .HSIZE(HSIZE), .HBURST(HBURST), .HPROT(HPROT),
    .HMASTLOCK(HMASTLOCK), .HWRITE(HWRITE), .HWDATA(HWDATA), .HREADY(HREADY),
    .HRDATA(HRDATA), .HRESP(HRESP)
  );

  typedef struct packed {
    logic        write;
    logic [31:0] addr;
    logic [31:0] data;
  } xfer_t;

  xfer_t exp_q[$];
  int    checks = 0;
  int    errors = 0;
  int    wait_states = 0;
  int    err_at = -1;
  int    xfer_idx = 0;
  int    wr_count = 0;

  // Slave state
  logic        in_data = 1'b0, a_busy = 1'b0, d_busy = 1'b0, d_write = 1'b0, d_err = 1'b0;
  int          a_left = 0, d_left = 0, err_step = 0;
  logic [31:0] a_addr = '0, d_addr = '0, d_exp = '0, d_wdata = '0;
  logic        a_write = 1'b0;

  function automatic logic [31:0] src_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin : slave
    xfer_t e;
    forever begin
      @(negedge HCLK);
      if (!HRESETn) begin
        in_data = 1'b0; a_busy = 1'b0; d_busy = 1'b0;
        HREADY = 1'b1; HRESP = 1'b0;
      end else begin
        HRESP = 1'b0;
        if (in_data) begin
          if (d_err) begin
            HRESP    = 1'b1;
            HREADY   = (err_step == 1);
            if (err_step == 1) in_data = 1'b0;
            err_step++;
          end else begin
            if (d_write) begin
              if (!d_busy) begin d_busy = 1'b1; d_wdata = HWDATA; end
              else chk("hwdata_stable", HWDATA, d_wdata);
            end
            if (d_left > 0) begin
              HREADY = 1'b0; d_left--;
            end else begin
              HREADY = 1'b1; in_data = 1'b0; d_busy = 1'b0;
              if (d_write) begin chk("hwdata", HWDATA, d_exp); wr_count++; end
              else HRDATA = src_word(d_addr);
            end
          end
        end else if (HTRANS == HTRANS_NONSEQ || a_busy) begin
          if (!a_busy) begin
            a_busy = 1'b1; a_addr = HADDR; a_write = HWRITE; a_left = wait_states;
          end else begin
            chk("haddr_stable", HADDR, a_addr);
            chk("hwrite_stable", {31'b0, HWRITE}, {31'b0, a_write});
            chk("htrans_stable", {30'b0, HTRANS}, {30'b0, HTRANS_NONSEQ});
          end
          if (a_left > 0) begin
            HREADY = 1'b0; a_left--;
          end else begin
            HREADY = 1'b1; a_busy = 1'b0; in_data = 1'b1;
            d_addr = HADDR; d_write = HWRITE; d_left = wait_states;
            d_err = (xfer_idx == err_at); err_step = 0;
            xfer_idx++;
            chk("xfer_expected", {31'b0, exp_q.size() != 0}, 32'd1);
            if (exp_q.size() != 0) begin
              e = exp_q.pop_front();
              chk("hwrite", {31'b0, HWRITE}, {31'b0, e.write});
              chk("haddr", HADDR, e.addr);
              d_exp = e.data;
            end
          end
        end else begin
          HREADY = 1'b1;
        end
      end
    end
  end

  task automatic run_copy(input string name, input logic [31:0] s, input logic [31:0] d,
                          input int n, input int waits, input int err_xfer, input int exp_cycles,
                          input logic exp_err, input logic [31:0] exp_err_addr, input int glitch_cyc);
    int          cyc;
    int          exp_wr;
    logic [31:0] sa;
    wait_states = waits; err_at = err_xfer; xfer_idx = 0; wr_count = 0; exp_wr = 0;
    for (int i = 0; i < 2 * n; i++) begin
      if (err_xfer >= 0 && i > err_xfer) break;
      sa = s + 32'(4 * (i / 2));
      if (i % 2 == 0) exp_q.push_back('{write: 1'b0, addr: sa, data: 32'h0});
      else begin
        exp_q.push_back('{write: 1'b1, addr: d + 32'(4 * (i / 2)), data: src_word(sa)});
        if (i != err_xfer) exp_wr++;
      end
    end
    @(negedge HCLK);
    srcAddr = s; dstAddr = d; wordCount = 16'(n); start = 1'b1;
    @(posedge HCLK);
    @(negedge HCLK);
    start = 1'b0;
    cyc = 1;
    chk({name, "_busy_c1"}, {31'b0, busy}, 32'd1);
    while (!done && cyc < 200) begin
      if (cyc == glitch_cyc) begin
        start = 1'b1; srcAddr = 32'h0000_0900; dstAddr = 32'h0000_0A00; wordCount = 16'd5;
      end
      @(negedge HCLK);
      start = 1'b0;
      cyc++;
    end
    chk({name, "_done_cycle"}, 32'(cyc), 32'(exp_cycles));
    chk({name, "_busy_at_done"}, {31'b0, busy}, 32'd1);
    chk({name, "_error"}, {31'b0, error}, {31'b0, exp_err});
    chk({name, "_erraddr"}, errAddr, exp_err_addr);
    // A start coinciding with the done pulse must be ignored.
    start = 1'b1; srcAddr = 32'hDEAD_0000; wordCount = 16'd1;
    @(negedge HCLK);
    start = 1'b0;
    chk({name, "_done_cleared"}, {31'b0, done}, 32'd0);
    chk({name, "_busy_cleared"}, {31'b0, busy}, 32'd0);
    chk({name, "_erraddr_held"}, errAddr, exp_err_addr);
    repeat (4) @(negedge HCLK);
    chk({name, "_htrans_idle"}, {30'b0, HTRANS}, {30'b0, HTRANS_IDLE});
    chk({name, "_queue_drained"}, 32'(exp_q.size()), 32'd0);
    chk({name, "_write_count"}, 32'(wr_count), 32'(exp_wr));
    exp_q.delete();
  endtask

  initial begin : main
    repeat (2) @(negedge HCLK);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_htrans", {30'b0, HTRANS}, {30'b0, HTRANS_IDLE});
    chk("rst_haddr", HADDR, 32'h0);
    chk("rst_hwdata", HWDATA, 32'h0);
    chk("const_hsize", {29'b0, HSIZE}, 32'd2);
    chk("const_hburst", {29'b0, HBURST}, 32'd0);
    chk("const_hprot", {28'b0, HPROT}, 32'd3);
    chk("const_hmastlock", {31'b0, HMASTLOCK}, 32'd0);
    HRESETn = 1'b1;
    repeat (2) @(negedge HCLK);

    run_copy("t1", 32'h0000_0100, 32'h0000_0200, 3, 0, -1, 13, 1'b0, 32'h0, -1);
    run_copy("t2", 32'h0000_1000, 32'h0000_2000, 1, 2, -1, 13, 1'b0, 32'h0, -1);
    run_copy("t3", 32'h0000_3000, 32'h0000_4000, 4, 0, 2, 8, 1'b1, 32'h0000_3004, -1);
    run_copy("t4", 32'h0000_0600, 32'h0000_0700, 0, 0, -1, 1, 1'b0, 32'h0, -1);
    run_copy("t5", 32'h0000_0300, 32'h0000_0400, 2, 0, -1, 9, 1'b0, 32'h0, 3);
    run_copy("t6", 32'hFFFF_FFFC, 32'h0000_0500, 2, 0, -1, 9, 1'b0, 32'h0, -1);

    // Reset asserted while the first read is in its data phase.
    wait_states = 0; err_at = -1; xfer_idx = 0;
    exp_q.push_back('{write: 1'b0, addr: 32'h0000_0800, data: 32'h0});
    @(negedge HCLK);
    srcAddr = 32'h0000_0800; dstAddr = 32'h0000_0880; wordCount = 16'd2; start = 1'b1;
    @(posedge HCLK);
    @(negedge HCLK);
    start = 1'b0;
    @(negedge HCLK);
    #1 HRESETn = 1'b0;
    #1;
    chk("arst_busy", {31'b0, busy}, 32'd0);
    chk("arst_done", {31'b0, done}, 32'd0);
    chk("arst_error", {31'b0, error}, 32'd0);
    chk("arst_erraddr", errAddr, 32'h0);
    chk("arst_haddr", HADDR, 32'h0);
    chk("arst_htrans", {30'b0, HTRANS}, {30'b0, HTRANS_IDLE});
    chk("arst_hwrite", {31'b0, HWRITE}, 32'd0);
    chk("arst_hwdata", HWDATA, 32'h0);
    repeat (3) begin
      @(negedge HCLK);
      chk("arst_no_done", {31'b0, done}, 32'd0);
    end
    HRESETn = 1'b1;
    repeat (4) begin
      @(negedge HCLK);
      chk("post_rst_no_done", {31'b0, done}, 32'd0);
    end
    chk("post_rst_busy", {31'b0, busy}, 32'd0);
    chk("post_rst_queue", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
